// File: rtl/pwchk_pkg.sv
// Shared types and width helpers for the password check / lockout block.
// Build option PWCHK_LOCK_BACKOFF_EN selects exponential lockout backoff.
package pwchk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    LOCKED  = 2'd2
  } pwchk_state_t;

  // Width of a counter that must hold 0..max_fails.
  function automatic int fail_cnt_w(input int max_fails);
    return $clog2(max_fails + 1);
  endfunction

  // Width of a down-counter whose largest loaded value is max_count-1.
  function automatic int timer_w(input int max_count);
    int w;
    w = $clog2(max_count);
    return (w < 1) ? 1 : w;
  endfunction

  // Width of the backoff exponent, which saturates at max_backoff.
  function automatic int exp_w(input int max_backoff);
    int w;
    w = $clog2(max_backoff + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pwchk_lock_timer.sv
// Loadable lockout down-counter; expired is high whenever the count is zero.
// With PWCHK_LOCK_BACKOFF_EN each load doubles the next duration up to MAX_BACKOFF.
module pwchk_lock_timer
  import pwchk_pkg::*;
#(
  parameter int TIMER_W     = 10,
  parameter int MAX_BACKOFF = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
`ifdef PWCHK_LOCK_BACKOFF_EN
  input  logic             clear_backoff,
`endif
  input  logic [TIMER_W:0] duration,
  output logic             expired
);

  logic [TIMER_W-1:0] count;
  logic [TIMER_W:0]   span;

`ifdef PWCHK_LOCK_BACKOFF_EN
  localparam int EXP_W = exp_w(MAX_BACKOFF);

  logic [EXP_W-1:0] exponent;

  // The current load uses the old exponent; the next lockout gets the doubled one.
  assign span = duration << exponent;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exponent <= '0;
    end else if (clear_backoff) begin
      exponent <= '0;
    end else if (load && (exponent < EXP_W'(MAX_BACKOFF))) begin
      exponent <= exponent + EXP_W'(1);
    end
  end
`else
  assign span = duration;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= TIMER_W'(span - (TIMER_W + 1)'(1));
    end else if (count != '0) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/password_check_lockout.sv
// Handshaked password check with reprogrammable golden value, session hold and
// timed lockout after MAX_FAILS misses. Option: PWCHK_LOCK_BACKOFF_EN.
module password_check_lockout
  import pwchk_pkg::*;
#(
  parameter int          PASS_W       = 32,
  parameter int          MAX_FAILS    = 3,
  parameter int          LOCK_CYCLES  = 1024,
  parameter logic [31:0] GOLDEN_RESET = 32'h0BAD_C0DE,
  parameter int          MAX_BACKOFF  = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             attempt_valid,
  output logic                             attempt_ready,
  input  logic [PASS_W-1:0]                entered_pass,
  input  logic                             logout,
  input  logic                             prog_valid,
  input  logic [PASS_W-1:0]                prog_pass,
  output logic                             grant_access,
  output logic                             deny,
  output logic                             prog_done,
  output logic                             locked,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count
);

  localparam int FAIL_W = fail_cnt_w(MAX_FAILS);
`ifdef PWCHK_LOCK_BACKOFF_EN
  localparam int TIMER_W = timer_w(LOCK_CYCLES << MAX_BACKOFF);
`else
  localparam int TIMER_W = timer_w(LOCK_CYCLES);
`endif
  localparam logic [TIMER_W:0] LOCK_DUR = (TIMER_W + 1)'(LOCK_CYCLES);

  pwchk_state_t      state, state_next;
  logic [FAIL_W-1:0] fail_next;
  logic [PASS_W-1:0] golden_pass, golden_next;
  logic              deny_next, prog_done_next;
  logic              accept, match, lock_load, lock_expired;
`ifdef PWCHK_LOCK_BACKOFF_EN
  logic              grant_now;
`endif

  assign attempt_ready = (state == IDLE);
  assign accept        = attempt_valid & attempt_ready;
  assign match         = (entered_pass == golden_pass);
  assign grant_access  = (state == GRANTED);
  assign locked        = (state == LOCKED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      fail_count  <= '0;
      golden_pass <= PASS_W'(GOLDEN_RESET);
      deny        <= 1'b0;
      prog_done   <= 1'b0;
    end else begin
      state       <= state_next;
      fail_count  <= fail_next;
      golden_pass <= golden_next;
      deny        <= deny_next;
      prog_done   <= prog_done_next;
    end
  end

  // Programming and logout in the same cycle both take effect.
  always_comb begin
    state_next     = state;
    fail_next      = fail_count;
    golden_next    = golden_pass;
    deny_next      = 1'b0;
    prog_done_next = 1'b0;
    lock_load      = 1'b0;
`ifdef PWCHK_LOCK_BACKOFF_EN
    grant_now      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          if (match) begin
            state_next = GRANTED;
            fail_next  = '0;
`ifdef PWCHK_LOCK_BACKOFF_EN
            grant_now  = 1'b1;
`endif
          end else begin
            deny_next = 1'b1;
            if (fail_count == FAIL_W'(MAX_FAILS - 1)) begin
              state_next = LOCKED;
              fail_next  = FAIL_W'(MAX_FAILS);
              lock_load  = 1'b1;
            end else begin
              fail_next = fail_count + FAIL_W'(1);
            end
          end
        end
      end
      GRANTED: begin
        if (prog_valid) begin
          golden_next    = prog_pass;
          prog_done_next = 1'b1;
        end
        if (logout) begin
          state_next = IDLE;
        end
      end
      LOCKED: begin
        if (lock_expired) begin
          state_next = IDLE;
          fail_next  = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  pwchk_lock_timer #(
    .TIMER_W     (TIMER_W),
    .MAX_BACKOFF (MAX_BACKOFF)
  ) u_lock_timer (
    .clk           (clk),
    .reset         (reset),
    .load          (lock_load),
`ifdef PWCHK_LOCK_BACKOFF_EN
    .clear_backoff (grant_now),
`endif
    .duration      (LOCK_DUR),
    .expired       (lock_expired)
  );

endmodule

// File: tb/tb_password_check_lockout.sv
// Directed self-checking bench for password_check_lockout (default parameters).
// Backoff durations are checked only when PWCHK_LOCK_BACKOFF_EN is defined.
module tb_password_check_lockout;

  localparam logic [31:0] GOLD  = 32'h0BAD_C0DE;
  localparam logic [31:0] WRONG = 32'h1234_5678;
  localparam logic [31:0] NEWPW = 32'hCAFE_F00D;
  localparam int          LOCKC = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        attempt_valid;
  logic        attempt_ready;
  logic [31:0] entered_pass;
  logic        logout;
  logic        prog_valid;
  logic [31:0] prog_pass;
  logic        grant_access;
  logic        deny;
  logic        prog_done;
  logic        locked;
  logic [1:0]  fail_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  password_check_lockout dut (
    .clk           (clk),
    .reset         (reset),
    .attempt_valid (attempt_valid),
    .attempt_ready (attempt_ready),
    .entered_pass  (entered_pass),
    .logout        (logout),
    .prog_valid    (prog_valid),
    .prog_pass     (prog_pass),
    .grant_access  (grant_access),
    .deny          (deny),
    .prog_done     (prog_done),
    .locked        (locked),
    .fail_count    (fail_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic attempt(input logic [31:0] pw);
    attempt_valid = 1'b1;
    entered_pass  = pw;
    tick();
    attempt_valid = 1'b0;
  endtask

  task automatic do_logout();
    logout = 1'b1;
    tick();
    logout = 1'b0;
  endtask

  // Counts locked samples from the current one until locked drops; -1 on timeout.
  task automatic measure_lock(output int cycles);
    cycles = 0;
    for (int i = 0; i < 20000; i++) begin
      if (!locked) return;
      cycles++;
      tick();
    end
    cycles = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; attempt_valid = 1'b0; entered_pass = '0;
    logout = 1'b0; prog_valid = 1'b0; prog_pass = '0;
    #12;
    checks++;
    if ({attempt_ready, grant_access, deny, prog_done, locked, fail_count} !== 7'b1000000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 1000000",
               {attempt_ready, grant_access, deny, prog_done, locked, fail_count});
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_grant();
    attempt(GOLD);
    checks++;
    if ({grant_access, attempt_ready, deny, fail_count} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL grant_after_accept: got %b expected 10000",
               {grant_access, attempt_ready, deny, fail_count});
    end
    do_logout();
    checks++;
    if ({grant_access, attempt_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL logout: got %b expected 01", {grant_access, attempt_ready});
    end
  endtask

  task automatic test_lockout();
    int cyc;
    for (int k = 1; k <= 3; k++) begin
      attempt(WRONG);
      checks++;
      if ({deny, fail_count, locked} !== {1'b1, 2'(k), (k == 3)}) begin
        errors++;
        $display("[TB] FAIL deny_fail%0d: got %b expected %b", k,
                 {deny, fail_count, locked}, {1'b1, 2'(k), (k == 3)});
      end
      if (k == 1) begin
        tick();
        checks++;
        if (deny !== 1'b0) begin
          errors++;
          $display("[TB] FAIL deny_pulse_width: got %b expected 0", deny);
        end
      end
    end
    checks++;
    if (attempt_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_in_lock: got %b expected 0", attempt_ready);
    end
    measure_lock(cyc);
    checks++;
    if (cyc != LOCKC) begin
      errors++;
      $display("[TB] FAIL lock_duration: got %0d expected %0d", cyc, LOCKC);
    end
    checks++;
    if ({attempt_ready, fail_count} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL after_unlock: got %b expected 100", {attempt_ready, fail_count});
    end
  endtask

  task automatic test_locked_hold();
    int  n;
    bit  early;
    for (int k = 0; k < 3; k++) attempt(WRONG);
    attempt_valid = 1'b1;
    entered_pass  = GOLD;
    early = 1'b0;
    n = 0;
    while (locked && n < 2000) begin
      if (grant_access) early = 1'b1;
      tick();
      n++;
    end
    checks++;
    if (early || n != LOCKC) begin
      errors++;
      $display("[TB] FAIL hold_in_lock: got early=%0d cycles=%0d expected early=0 cycles=%0d",
               early, n, LOCKC);
    end
    tick();
    attempt_valid = 1'b0;
    checks++;
    if (grant_access !== 1'b1) begin
      errors++;
      $display("[TB] FAIL grant_after_unlock: got %b expected 1", grant_access);
    end
    do_logout();
  endtask

  task automatic test_prog_logout();
    prog_valid = 1'b1; prog_pass = 32'hDEAD_BEEF;
    tick();
    prog_valid = 1'b0;
    checks++;
    if (prog_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prog_in_idle: got %b expected 0", prog_done);
    end
    attempt(GOLD);
    prog_valid = 1'b1; prog_pass = NEWPW; logout = 1'b1;
    tick();
    prog_valid = 1'b0; logout = 1'b0;
    checks++;
    if ({prog_done, grant_access, attempt_ready} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL prog_and_logout: got %b expected 101",
               {prog_done, grant_access, attempt_ready});
    end
    tick();
    checks++;
    if (prog_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prog_done_pulse: got %b expected 0", prog_done);
    end
    attempt(GOLD);
    checks++;
    if ({deny, grant_access, fail_count} !== 4'b1001) begin
      errors++;
      $display("[TB] FAIL old_pw_denied: got %b expected 1001", {deny, grant_access, fail_count});
    end
    attempt(NEWPW);
    checks++;
    if ({grant_access, fail_count} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL new_pw_grants: got %b expected 100", {grant_access, fail_count});
    end
    do_logout();
  endtask

  task automatic test_fail_clear();
    attempt(WRONG);
    attempt(WRONG);
    checks++;
    if (fail_count !== 2'd2) begin
      errors++;
      $display("[TB] FAIL two_fails: got %0d expected 2", fail_count);
    end
    attempt(NEWPW);
    checks++;
    if ({grant_access, fail_count} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL match_clears: got %b expected 100", {grant_access, fail_count});
    end
    do_logout();
    attempt(WRONG);
    attempt(WRONG);
    tick();
    checks++;
    if ({locked, attempt_ready, fail_count} !== 4'b0110) begin
      errors++;
      $display("[TB] FAIL no_early_lock: got %b expected 0110",
               {locked, attempt_ready, fail_count});
    end
    attempt(NEWPW);
    do_logout();
  endtask

  task automatic test_reset_mid_lock();
    for (int k = 0; k < 3; k++) attempt(WRONG);
    repeat (500) tick();
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("[TB] FAIL still_locked: got %b expected 1", locked);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({locked, attempt_ready, fail_count} !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL async_reset_lock: got %b expected 0100",
               {locked, attempt_ready, fail_count});
    end
    tick();
    reset = 1'b0;
    tick();
    attempt(GOLD);
    checks++;
    if (grant_access !== 1'b1) begin
      errors++;
      $display("[TB] FAIL golden_restored: got %b expected 1", grant_access);
    end
    do_logout();
  endtask

`ifdef PWCHK_LOCK_BACKOFF_EN
  task automatic test_backoff();
    int cyc;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) attempt(WRONG);
      measure_lock(cyc);
      checks++;
      if (cyc != (LOCKC << r)) begin
        errors++;
        $display("[TB] FAIL backoff_%0d: got %0d expected %0d", r, cyc, LOCKC << r);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_grant();
    test_lockout();
    test_locked_hold();
    test_prog_logout();
    test_fail_clear();
    test_reset_mid_lock();
`ifdef PWCHK_LOCK_BACKOFF_EN
    test_backoff();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
